// File: rtl/ctrl_seq_pkg.sv
// Shared types and default constants for the control microsequencer.
// Contents:
//   state_e                    - sequencer state, IDLE=0 and T0..T7=1..8, 4-bit encoding
//   DefOp*                     - default IR opcodes for ld / ldi / st / addi
//   DefAluAdd                  - default ALU add code driven on alu_op in T4
package ctrl_seq_pkg;

  typedef enum logic [3:0] {
    StIdle = 4'd0,
    StT0   = 4'd1,
    StT1   = 4'd2,
    StT2   = 4'd3,
    StT3   = 4'd4,
    StT4   = 4'd5,
    StT5   = 4'd6,
    StT6   = 4'd7,
    StT7   = 4'd8
  } state_e;

  localparam logic [4:0] DefOpLd   = 5'b00000;
  localparam logic [4:0] DefOpLdi  = 5'b00001;
  localparam logic [4:0] DefOpSt   = 5'b00010;
  localparam logic [4:0] DefOpAddi = 5'b01100;
  localparam logic [4:0] DefAluAdd = 5'b00011;

endpackage

// File: rtl/mem_wait_ctr.sv
// Memory-state wait timer for the control sequencer.
// Build option: CTRL_MEM_HANDSHAKE_EN
//   defined   - expired follows ready directly; the memory state ends on the edge that
//               samples ready high. MEM_LAT, start, Clock and clear are unused.
//   undefined - a down-counter loaded with MEM_LAT on entry to a memory state; expired
//               is high on the last of the MEM_LAT cycles. ready is unused.
// Ports:
//   Clock   in  clock, rising edge
//   clear   in  asynchronous active-low reset (counter to 0)
//   start   in  high on the cycle whose closing edge enters a memory state
//   ready   in  memory access complete (handshake build only)
//   expired out the current memory state may advance on the next edge
module mem_wait_ctr #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic Clock,
  input  logic clear,
  input  logic start,
  input  logic ready,
  output logic expired
);

`ifdef CTRL_MEM_HANDSHAKE_EN

  logic unused_inputs;
  assign unused_inputs = ^{Clock, clear, start};

  assign expired = ready;

`else

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            unused_ready;

  assign unused_ready = ready;

  // The count is only nonzero inside a memory state, so free-running decrement to 0 is safe.
  always_comb begin
    cnt_d = cnt_q;
    if (start) begin
      cnt_d = CntW'(MEM_LAT);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == CntW'(1));

`endif

endmodule

// File: rtl/ctrl_sequencer.sv
// Microsequencer producing per-T-state datapath strobes for instruction fetch and the
// ld / ldi / st / addi class. Strobes are a Moore decode of the registered state (and of
// ir_opcode from T3 on). Memory states (T1, T6 of ld, T7 of st) hold their strobes until
// mem_wait_ctr reports the access complete.
// Build option: CTRL_MEM_HANDSHAKE_EN selects the mem_ready handshake instead of the
// fixed MEM_LAT latency (see mem_wait_ctr).
// Ports:
//   Clock, clear           clock (rising edge) and asynchronous active-low reset
//   run                    start request, sampled in IDLE and on done
//   ir_opcode[4:0]         IR[31:27], valid from T3 onward
//   mem_ready              memory access complete (handshake build only)
//   PCout .. Cout          datapath strobes
//   alu_op[4:0]            ALU operation, ALU_ADD in T4 else 0
//   state[3:0]             current state code
//   busy / done / illegal  not idle / last T-state pulse / unsupported opcode pulse
module ctrl_sequencer
  import ctrl_seq_pkg::*;
#(
  parameter logic [4:0]  OP_LD   = DefOpLd,
  parameter logic [4:0]  OP_LDI  = DefOpLdi,
  parameter logic [4:0]  OP_ST   = DefOpSt,
  parameter logic [4:0]  OP_ADDI = DefOpAddi,
  parameter logic [4:0]  ALU_ADD = DefAluAdd,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic       Clock,
  input  logic       clear,
  input  logic       run,
  input  logic [4:0] ir_opcode,
  input  logic       mem_ready,
  output logic       PCout,
  output logic       MARin,
  output logic       IncPC,
  output logic       Zin,
  output logic       Zlowout,
  output logic       PCin,
  output logic       Read,
  output logic       Write,
  output logic       MDRin,
  output logic       MDRout,
  output logic       IRin,
  output logic       Yin,
  output logic       Gra,
  output logic       Grb,
  output logic       Grc,
  output logic       Rin,
  output logic       Rout,
  output logic       BAout,
  output logic       Cout,
  output logic [4:0] alu_op,
  output logic [3:0] state,
  output logic       busy,
  output logic       done,
  output logic       illegal
);

  state_e state_q, state_d;
  logic   is_ld, is_ldi, is_st, is_addi;
  logic   expired, wait_start;

  assign is_ld   = (ir_opcode == OP_LD);
  assign is_ldi  = (ir_opcode == OP_LDI);
  assign is_st   = (ir_opcode == OP_ST);
  assign is_addi = (ir_opcode == OP_ADDI);

  function automatic logic is_mem_state(input state_e s, input logic ld, input logic st);
    return (s == StT1) || ((s == StT6) && ld) || ((s == StT7) && st);
  endfunction

  // Load the wait timer on the edge that enters a memory state.
  assign wait_start = is_mem_state(state_d, is_ld, is_st) && (state_d != state_q);

  mem_wait_ctr #(
    .MEM_LAT(MEM_LAT)
  ) u_mem_wait_ctr (
    .Clock  (Clock),
    .clear  (clear),
    .start  (wait_start),
    .ready  (mem_ready),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    Zin     = 1'b0;
    Zlowout = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    Write   = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    Gra     = 1'b0;
    Grb     = 1'b0;
    Grc     = 1'b0;
    Rin     = 1'b0;
    Rout    = 1'b0;
    BAout   = 1'b0;
    Cout    = 1'b0;
    alu_op  = 5'd0;
    done    = 1'b0;
    illegal = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (run) state_d = StT0;
      end
      StT0: begin
        PCout   = 1'b1;
        MARin   = 1'b1;
        IncPC   = 1'b1;
        Zin     = 1'b1;
        state_d = StT1;
      end
      StT1: begin
        Zlowout = 1'b1;
        PCin    = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        if (expired) state_d = StT2;
      end
      StT2: begin
        MDRout  = 1'b1;
        IRin    = 1'b1;
        state_d = StT3;
      end
      StT3: begin
        if (is_ld || is_ldi || is_st) begin
          Grb     = 1'b1;
          BAout   = 1'b1;
          Yin     = 1'b1;
          state_d = StT4;
        end else if (is_addi) begin
          Grb     = 1'b1;
          Rout    = 1'b1;
          Yin     = 1'b1;
          state_d = StT4;
        end else begin
          illegal = 1'b1;
          state_d = StIdle;
        end
      end
      StT4: begin
        Cout    = 1'b1;
        Zin     = 1'b1;
        alu_op  = ALU_ADD;
        state_d = StT5;
      end
      StT5: begin
        if (is_ld || is_st) begin
          Zlowout = 1'b1;
          MARin   = 1'b1;
          state_d = StT6;
        end else if (is_ldi || is_addi) begin
          Zlowout = 1'b1;
          Gra     = 1'b1;
          Rin     = 1'b1;
          done    = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StT6: begin
        if (is_ld) begin
          Read  = 1'b1;
          MDRin = 1'b1;
          if (expired) state_d = StT7;
        end else if (is_st) begin
          Gra     = 1'b1;
          Rout    = 1'b1;
          MDRin   = 1'b1;
          state_d = StT7;
        end else begin
          state_d = StIdle;
        end
      end
      StT7: begin
        if (is_ld) begin
          MDRout = 1'b1;
          Gra    = 1'b1;
          Rin    = 1'b1;
          done   = 1'b1;
        end else if (is_st) begin
          Write = 1'b1;
          // done marks only the final wait cycle so it stays a single-cycle pulse.
          done  = expired;
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (done) state_d = run ? StT0 : StIdle;
  end

  always_ff @(posedge Clock or negedge clear) begin
    if (!clear) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;
  assign busy  = (state_q != StIdle);

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Scoreboard bench for ctrl_sequencer. Each instruction is expanded from a table of
// T-state phases into per-cycle expected output vectors; a monitor compares one vector
// per cycle on the falling edge.
module tb_ctrl_sequencer;

  localparam int unsigned MemLat = 3;

  localparam logic [4:0] OpLd   = 5'b00000;
  localparam logic [4:0] OpLdi  = 5'b00001;
  localparam logic [4:0] OpSt   = 5'b00010;
  localparam logic [4:0] OpAddi = 5'b01100;
  localparam logic [4:0] AluAdd = 5'b00011;

  localparam logic [18:0] M_PCOUT   = 19'h1 << 0;
  localparam logic [18:0] M_MARIN   = 19'h1 << 1;
  localparam logic [18:0] M_INCPC   = 19'h1 << 2;
  localparam logic [18:0] M_ZIN     = 19'h1 << 3;
  localparam logic [18:0] M_ZLOWOUT = 19'h1 << 4;
  localparam logic [18:0] M_PCIN    = 19'h1 << 5;
  localparam logic [18:0] M_READ    = 19'h1 << 6;
  localparam logic [18:0] M_WRITE   = 19'h1 << 7;
  localparam logic [18:0] M_MDRIN   = 19'h1 << 8;
  localparam logic [18:0] M_MDROUT  = 19'h1 << 9;
  localparam logic [18:0] M_IRIN    = 19'h1 << 10;
  localparam logic [18:0] M_YIN     = 19'h1 << 11;
  localparam logic [18:0] M_GRA     = 19'h1 << 12;
  localparam logic [18:0] M_GRB     = 19'h1 << 13;
  localparam logic [18:0] M_RIN     = 19'h1 << 15;
  localparam logic [18:0] M_ROUT    = 19'h1 << 16;
  localparam logic [18:0] M_BAOUT   = 19'h1 << 17;
  localparam logic [18:0] M_COUT    = 19'h1 << 18;

  logic       Clock = 1'b0;
  logic       clear = 1'b1;
  logic       run = 1'b0;
  logic       mem_ready = 1'b0;
  logic [4:0] ir_opcode = 5'd0;
  logic PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout, IRin;
  logic Yin, Gra, Grb, Grc, Rin, Rout, BAout, Cout, busy, done, illegal;
  logic [4:0] alu_op;
  logic [3:0] state;
  logic [30:0] act;

  typedef struct {
    logic [30:0] exp;
    logic        r;
    logic        mr;
    logic [4:0]  op;
  } cyc_t;

  cyc_t        plan[$];
  logic [30:0] exp_q[$];
  int          checks = 0;
  int          passes = 0;

  ctrl_sequencer #(
    .MEM_LAT(MemLat)
  ) dut (
    .Clock    (Clock),
    .clear    (clear),
    .run      (run),
    .ir_opcode(ir_opcode),
    .mem_ready(mem_ready),
    .PCout    (PCout),
    .MARin    (MARin),
    .IncPC    (IncPC),
    .Zin      (Zin),
    .Zlowout  (Zlowout),
    .PCin     (PCin),
    .Read     (Read),
    .Write    (Write),
    .MDRin    (MDRin),
    .MDRout   (MDRout),
    .IRin     (IRin),
    .Yin      (Yin),
    .Gra      (Gra),
    .Grb      (Grb),
    .Grc      (Grc),
    .Rin      (Rin),
    .Rout     (Rout),
    .BAout    (BAout),
    .Cout     (Cout),
    .alu_op   (alu_op),
    .state    (state),
    .busy     (busy),
    .done     (done),
    .illegal  (illegal)
  );

  always #5 Clock = ~Clock;

  assign act = {illegal, done, busy, state, alu_op, Cout, BAout, Rout, Rin, Grc, Grb, Gra,
                Yin, IRin, MDRout, MDRin, Write, Read, PCin, Zlowout, Zin, IncPC, MARin, PCout};

  function automatic logic [30:0] mk(input int st, input logic [18:0] s, input logic [4:0] alu,
                                     input bit dn, input bit il);
    logic [3:0] sc;
    logic       bz;
    sc = 4'(st);
    bz = (st != 0);
    return {il, dn, bz, sc, alu, s};
  endfunction

  function automatic void check(input string nm, input logic [30:0] got, input logic [30:0] want);
    checks++;
    if (got === want) begin
      passes++;
    end else begin
      $display("FAIL %s @%0t: got state=%0d vec=%h, expected state=%0d vec=%h",
               nm, $time, got[27:24], got, want[27:24], want);
    end
  endfunction

  // One T-state phase: memory phases span the access time, done only on the final cycle.
  function automatic void add_phase(input int st, input logic [18:0] s, input logic [4:0] alu,
                                    input bit mem, input bit dn, input bit il, input bit cont,
                                    input logic [4:0] op, input bit junk);
    int   n;
    bit   last;
    cyc_t c;
`ifdef CTRL_MEM_HANDSHAKE_EN
    n = mem ? 1 + int'($urandom_range(0, 3)) : 1;
`else
    n = mem ? int'(MemLat) : 1;
`endif
    for (int i = 0; i < n; i++) begin
      last  = (i == n - 1);
      c.exp = mk(st, s, alu, dn && last, il);
      c.r   = (dn && last) ? 1'(cont) : 1'($urandom_range(0, 1));
`ifdef CTRL_MEM_HANDSHAKE_EN
      c.mr  = mem ? 1'(last) : 1'($urandom_range(0, 1));
`else
      c.mr  = 1'($urandom_range(0, 1));
`endif
      c.op  = junk ? 5'($urandom) : op;
      plan.push_back(c);
    end
  endfunction

  // Returns 1 when the instruction ends with done and run=1 (back-to-back start).
  function automatic bit build_instr(input logic [4:0] op, input bit cont);
    bit ld, ldi, st, addi;
    ld   = (op == OpLd);
    ldi  = (op == OpLdi);
    st   = (op == OpSt);
    addi = (op == OpAddi);
    add_phase(1, M_PCOUT | M_MARIN | M_INCPC | M_ZIN, 5'd0, 0, 0, 0, cont, op, 1);
    add_phase(2, M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN, 5'd0, 1, 0, 0, cont, op, 1);
    add_phase(3, M_MDROUT | M_IRIN, 5'd0, 0, 0, 0, cont, op, 1);
    if (!(ld || ldi || st || addi)) begin
      add_phase(4, 19'd0, 5'd0, 0, 0, 1, cont, op, 0);
      return 1'b0;
    end
    add_phase(4, M_GRB | M_YIN | (addi ? M_ROUT : M_BAOUT), 5'd0, 0, 0, 0, cont, op, 0);
    add_phase(5, M_COUT | M_ZIN, AluAdd, 0, 0, 0, cont, op, 0);
    if (ldi || addi) begin
      add_phase(6, M_ZLOWOUT | M_GRA | M_RIN, 5'd0, 0, 1, 0, cont, op, 0);
      return cont;
    end
    add_phase(6, M_ZLOWOUT | M_MARIN, 5'd0, 0, 0, 0, cont, op, 0);
    if (ld) begin
      add_phase(7, M_READ | M_MDRIN, 5'd0, 1, 0, 0, cont, op, 0);
      add_phase(8, M_MDROUT | M_GRA | M_RIN, 5'd0, 0, 1, 0, cont, op, 0);
    end else begin
      add_phase(7, M_GRA | M_ROUT | M_MDRIN, 5'd0, 0, 0, 0, cont, op, 0);
      add_phase(8, M_WRITE, 5'd0, 1, 1, 0, cont, op, 0);
    end
    return cont;
  endfunction

  // k idle cycles with run low, then (if go) one idle cycle requesting a start.
  function automatic void add_idle(input int k, input bit go);
    cyc_t c;
    c.exp = '0;
    for (int i = 0; i < k + (go ? 1 : 0); i++) begin
      c.r  = (i == k);
      c.mr = 1'($urandom_range(0, 1));
      c.op = 5'($urandom);
      plan.push_back(c);
    end
  endfunction

  task automatic play(input int n);
    cyc_t c;
    for (int i = 0; i < n && plan.size() > 0; i++) begin
      c = plan.pop_front();
      @(posedge Clock);
      #1;
      run       = c.r;
      mem_ready = c.mr;
      ir_opcode = c.op;
      exp_q.push_back(c.exp);
    end
  endtask

  task automatic seq(input logic [4:0] op, input bit cont);
    bit more;
    more = build_instr(op, cont);
    if (!more) add_idle(int'($urandom_range(0, 2)), 1);
    play(plan.size());
  endtask

  always @(negedge Clock) begin
    logic [30:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("cycle", act, e);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got time %0t, required < 2000000", $time);
    $fatal(1);
  end

  initial begin
    int          idx;
    logic [4:0]  op;
    logic [4:0]  ops[4];
    ops[0] = OpLd;
    ops[1] = OpLdi;
    ops[2] = OpSt;
    ops[3] = OpAddi;

    #2 clear = 1'b0;
    #1 check("reset_outputs", act, '0);
    @(posedge Clock);
    #1 clear = 1'b1;

    add_idle(1, 1);
    play(plan.size());
    seq(OpLd, 0);
    seq(OpLdi, 0);
    seq(OpSt, 0);
    seq(5'b11111, 0);
    seq(OpAddi, 1);
    seq(OpAddi, 0);

    // Asynchronous clear in the first T6 cycle of ld.
    void'(build_instr(OpLd, 0));
    idx = 0;
    while (plan[idx].exp[27:24] != 4'd7) idx++;
    play(idx + 1);
    plan.delete();
    @(negedge Clock);
    #2 clear = 1'b0;
    #1 check("async_clear", act, '0);
    for (int i = 0; i < 2; i++) begin
      @(posedge Clock);
      #1 run = 1'b1;
      exp_q.push_back('0);
    end
    @(posedge Clock);
    #1 clear = 1'b1;
    run = 1'b1;
    exp_q.push_back('0);
    seq(OpLd, 0);

    for (int n = 0; n < 60; n++) begin
      op = ($urandom_range(0, 4) == 0) ? 5'($urandom) : ops[$urandom_range(0, 3)];
      seq(op, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge Clock);
    @(negedge Clock);
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      $display("FAIL drain: got %0d unchecked cycles, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/ctrl_sequencer.md
# ctrl_sequencer

Parametrised microsequencer that generates the per-T-state datapath control strobes for instruction fetch and the memory/immediate class: `ld`, `ldi`, `st`, `addi`. It sits beside `datapath` and drives its control inputs, replacing hand-sequenced strobes. Memory accesses stall the sequence either on a ready handshake or for a fixed latency.

## Interface
- `OP_LD`, default 5'b00000: IR opcode for `ld`.
- `OP_LDI`, default 5'b00001: IR opcode for `ldi`.
- `OP_ST`, default 5'b00010: IR opcode for `st`.
- `OP_ADDI`, default 5'b01100: IR opcode for `addi`.
- `ALU_ADD`, default 5'b00011: ALU add code driven on `alu_op`.
- `MEM_LAT`, default 1: memory cycles per access when the handshake is compiled out. Must be ≥1.
- `Clock  in  1`: single clock, rising edge.
- `clear  in  1`: reset, asynchronous, active-low.
- `run  in  1`: start request; sampled in IDLE and on completion.
- `ir_opcode  in  5`: IR[31:27], valid from T3 onward.
- `mem_ready  in  1`: memory access complete. Used only with `CTRL_MEM_HANDSHAKE_EN`.
- `PCout, MARin, IncPC, Zin, Zlowout, PCin, Read, Write, MDRin, MDRout, IRin, Yin, Gra, Grb, Grc, Rin, Rout, BAout, Cout  out  1 each`: datapath strobes.
- `alu_op  out  5`: ALU operation.
- `state  out  4`: current state code.
- `busy  out  1`: high in any state except IDLE.
- `done  out  1`: one-cycle pulse in the last T-state of an instruction.
- `illegal  out  1`: one-cycle pulse on an unsupported opcode.

## Operation
- States: IDLE=0, T0..T7=1..8. Strobes are a Moore decode of the registered state and of `ir_opcode` in T3+. All strobes are 0 in IDLE. `alu_op` is 0 except in T4.
- **Fetch**
  - T0: PCout, MARin, IncPC, Zin.
  - T1: Zlowout, PCin, Read, MDRin.
  - T2: MDRout, IRin.
- **T3**
  - `ld`/`ldi`/`st`: Grb, BAout, Yin.
  - `addi`: Grb, Rout, Yin.
  - Other opcodes: `illegal`=1, no strobes; next state is IDLE.
- **T4**: Cout, Zin, `alu_op`=ALU_ADD.
- **T5**
  - `ld`/`st`: Zlowout, MARin.
  - `ldi`/`addi`: Zlowout, Gra, Rin, `done`.
- **T6**
  - `ld`: Read, MDRin.
  - `st`: Gra, Rout, MDRin.
- **T7**
  - `ld`: MDRout, Gra, Rin, `done`.
  - `st`: Write, `done`.
- **Memory states** are T1, T6 for `ld`, and T7 for `st`. They hold their strobes until the access completes (see Configuration). All other states last exactly one cycle.
- **Transitions**
  - IDLE→T0 when `run`=1.
  - On `done`: →T0 if `run`=1, else →IDLE.
- Strobe values in a memory state are constant across all of its wait cycles. IncPC therefore asserts for exactly one cycle per instruction.

## Timing
- Reset (`clear`=0, asynchronous): state=IDLE, every output 0, wait counter 0. This applies mid-instruction too; no strobe survives the reset edge.
- Instruction length with single-cycle memory:
  - `ldi`/`addi`: 6 cycles.
  - `ld`/`st`: 8 cycles.
- Each memory state adds its wait cycles beyond the first.
- `run` deasserting mid-instruction has no effect until `done`.
- `mem_ready` asserting outside a memory state is ignored.
- `mem_ready` already high on entry to a memory state: the state lasts 1 cycle.

## Configuration
- `CTRL_MEM_HANDSHAKE_EN` defined: a memory state holds until a rising edge samples `mem_ready`=1; that edge advances the state. `MEM_LAT` is ignored.
- Undefined: each memory state lasts exactly `MEM_LAT` cycles, timed by a down-counter of width $clog2(MEM_LAT+1). Loaded on entry, advancing at 1. `mem_ready` is unused.

## Structure
- Package `ctrl_seq_pkg`: state enum (IDLE, T0..T7, 4-bit), default opcode constants, `ALU_ADD`.
- One sub-module `mem_wait_ctr`:
  - Inputs: `start`, `ready`.
  - Output: `expired`.
  - Implements both macro variants, so the top FSM is identical in each.

## Test plan
- Reset then `run`=1, `ir_opcode`=00000 (`ld`), MEM_LAT=1:
  - states 1→8 in 8 cycles.
  - T7 shows MDRout=Gra=Rin=1 and `done`=1.
  - `run`=0 at `done` → IDLE, all strobes 0.
- `ldi` (00001):
  - `done` in T5 with Zlowout=Gra=Rin=1.
  - `alu_op`=00011 only in T4.
  - 6 cycles total.
- `st` (00010) with handshake, `mem_ready` high 3 cycles after T7 entry:
  - Write held 4 cycles, then `done`.
  - T1 and T6 unaffected if ready is already high.
- Opcode 11111:
  - `illegal` pulses in T3, next state IDLE.
  - No Gra/Rin/Write ever asserted.
- `clear`=0 during T6 of `ld`: Read and MDRin drop the same instant, state=0. Release plus `run` restarts at T0.
- `run` held high over two `addi`: second T0 immediately follows first T5, IncPC pulses exactly twice.
